// File: rtl/axi_ram_rd_arbiter_if.sv
// Bundle of requester-side and AXI read-channel signals for axi_ram_rd_arbiter.
// master = the arbiter, slave = requesters plus the AXI slave RAM.
interface axi_ram_rd_arbiter_if #(
  parameter int NUM_REQ          = 2,
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int ID_WIDTH         = 3
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*8-1:0]                req_len;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [NUM_REQ-1:0]                  rsp_ready;
  logic [C_AXI_DATA_WIDTH-1:0]         rsp_data;
  logic                                rsp_last;
  logic                                rsp_err;

  logic [ID_WIDTH-1:0]                 m_axi_arid;
  logic [C_AXI_ADDR_WIDTH-1:0]         m_axi_araddr;
  logic [7:0]                          m_axi_arlen;
  logic [2:0]                          m_axi_arsize;
  logic [1:0]                          m_axi_arburst;
  logic                                m_axi_arvalid;
  logic                                m_axi_arready;
  logic [ID_WIDTH-1:0]                 m_axi_rid;
  logic [C_AXI_DATA_WIDTH-1:0]         m_axi_rdata;
  logic [1:0]                          m_axi_rresp;
  logic                                m_axi_rlast;
  logic                                m_axi_rvalid;
  logic                                m_axi_rready;

  modport master (
    input  req_valid, req_addr, req_len, rsp_ready,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output req_valid, req_addr, req_len, rsp_ready,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi_ram_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR/R) among NUM_REQ burst
// requesters; one outstanding INCR burst, R beats routed back to the grantee.
module axi_ram_rd_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int ID_WIDTH         = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_ram_rd_arbiter_if.master   bus,
  output logic [1:0]             dbg_state
);

  localparam int         GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] ARSIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));

  if (ID_WIDTH < $clog2(NUM_REQ)) begin : g_bad_id_width
    $error("axi_ram_rd_arbiter: ID_WIDTH must be >= clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("axi_ram_rd_arbiter: NUM_REQ must be in 2..8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [GW-1:0]               rr_ptr_q;
  logic [GW-1:0]               grant_q;
  logic [GW-1:0]               pick;
  logic                        pick_vld;
  logic [7:0]                  beat_cnt_q;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]                  arlen_q;
  logic [ID_WIDTH-1:0]         arid_q;
  logic                        err_q;
  logic                        err_now;
  logic                        ar_hs;
  logic                        r_hs;
  logic [NUM_REQ-1:0]          grant_oh;

  logic [C_AXI_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [7:0]                  len_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
    assign len_arr[i]  = bus.req_len[i*8 +: 8];
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a raised valid (and its payload)
  // is held until that edge. Requesters see req_ready as their AR handshake.
  assign ar_hs    = (state_q == S_AR) && bus.m_axi_arready;
  assign r_hs     = (state_q == S_DATA) && bus.m_axi_rvalid && bus.rsp_ready[grant_q];
  assign grant_oh = NUM_REQ'(1) << grant_q;

  // First requesting index at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && bus.req_valid[GW'(idx)]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_AR;
      S_AR:    if (ar_hs) state_d = S_DATA;
      S_DATA:  if (r_hs && bus.m_axi_rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A beat beyond the announced length keeps the FSM in DATA until rlast.
  always_comb begin
    err_now = 1'b0;
    if (state_q != S_DATA && bus.m_axi_rvalid) err_now = 1'b1;
    if (r_hs) begin
      if (bus.m_axi_rid != arid_q)                    err_now = 1'b1;
      if (bus.m_axi_rresp != 2'b00)                   err_now = 1'b1;
      if (bus.m_axi_rlast && beat_cnt_q != 8'd0)      err_now = 1'b1;
      if (!bus.m_axi_rlast && beat_cnt_q == 8'd0)     err_now = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && pick_vld) begin
        grant_q  <= pick;
        araddr_q <= addr_arr[pick];
        arlen_q  <= len_arr[pick];
        arid_q   <= ID_WIDTH'(pick);
      end
      if (ar_hs) begin
        beat_cnt_q <= arlen_q;
      end else if (r_hs && beat_cnt_q != 8'd0) begin
        beat_cnt_q <= beat_cnt_q - 8'd1;
      end
      if (r_hs && bus.m_axi_rlast) begin
        rr_ptr_q <= (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + GW'(1);
      end
      if (err_now) err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.m_axi_arvalid = (state_q == S_AR);
    bus.req_ready     = ar_hs ? grant_oh : '0;
    bus.m_axi_rready  = 1'b0;
    bus.rsp_valid     = '0;
    bus.rsp_data      = '0;
    bus.rsp_last      = 1'b0;
    if (state_q == S_DATA) begin
      bus.m_axi_rready = bus.rsp_ready[grant_q];
      bus.rsp_valid    = bus.m_axi_rvalid ? grant_oh : '0;
      bus.rsp_data     = bus.m_axi_rdata;
      bus.rsp_last     = bus.m_axi_rlast;
    end
  end

  assign bus.m_axi_arid    = arid_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = ARSIZE;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.rsp_err       = err_q;
  assign dbg_state         = state_q;

endmodule
